// File: rtl/mano_mem_pkg.sv
// rtl/mano_mem_pkg.sv - shared sizes, wait defaults and FSM encoding for the main-memory controller
package mano_mem_pkg;

  localparam int MEMCAP      = 4096;
  localparam int ADDRWIDTH   = 12;
  localparam int DATAWIDTH   = 16;
  localparam int RD_WAIT_DEF = 3;
  localparam int WR_WAIT_DEF = 2;

  typedef enum logic [2:0] {
    MS_IDLE    = 3'd0,
    MS_RD_WAIT = 3'd1,
    MS_RD_RSP  = 3'd2,
    MS_WR_WAIT = 3'd3,
    MS_DRAIN   = 3'd4
  } mem_state_e;

  function automatic logic [3:0] wait_load(input int w);
    return w[3:0];
  endfunction

endpackage

// File: rtl/mano_mem_array.sv
// rtl/mano_mem_array.sv - synchronous single-port backing store, registered read, contents never reset
module mano_mem_array
  import mano_mem_pkg::*;
#(
  parameter int ADDR_W = ADDRWIDTH,
  parameter int DATA_W = DATAWIDTH,
  parameter int DEPTH  = MEMCAP
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read-before-write: rdata reflects the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mano_mem_ctrl.sv
// rtl/mano_mem_ctrl.sv - main-memory controller FSM with wait states and valid/ready handshake
// Define MANO_MEM_WBUF_EN to add the one-entry posted-write buffer (DRAIN state with read forwarding).
module mano_mem_ctrl
  import mano_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDRWIDTH,
  parameter int DATA_W  = DATAWIDTH,
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  output logic              proto_err
);

  localparam logic [3:0] RD_LOAD = wait_load(RD_WAIT);
  localparam logic [3:0] WR_LOAD = wait_load(WR_WAIT);
`ifdef MANO_MEM_WBUF_EN
  localparam mem_state_e WR_STATE = MS_DRAIN;
`else
  localparam mem_state_e WR_STATE = MS_WR_WAIT;
`endif

  mem_state_e        st_q, st_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              wr_done_q, wr_done_d;
  logic              proto_err_q, proto_err_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_from_arr_q, rsp_from_arr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic              acc, acc_rd, acc_wr;

  // While draining, addr_q/wdata_q are the posted-write buffer; only a matching read may pass.
`ifdef MANO_MEM_WBUF_EN
  logic drain_stall;
  assign drain_stall = (st_q == MS_DRAIN) &&
                       ((req_wr && !req_rd) || (req_rd && (req_addr != addr_q)));
  assign req_ready   = req_ready_q && !drain_stall;
`else
  assign req_ready   = req_ready_q;
`endif

  assign acc    = req_ready && (req_rd || req_wr);
  assign acc_rd = acc && req_rd;
  assign acc_wr = acc && req_wr && !req_rd;

  always_comb begin
    st_d           = st_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rsp_valid_d    = 1'b0;
    wr_done_d      = 1'b0;
    proto_err_d    = acc && req_rd && req_wr;
    rsp_from_arr_d = 1'b0;
    rsp_rdata_d    = rsp_from_arr_q ? arr_rdata : rsp_rdata_q;
    arr_we         = 1'b0;
    arr_addr       = addr_q;
    arr_wdata      = wdata_q;
    unique case (st_q)
      MS_IDLE, MS_RD_RSP: begin
        st_d      = MS_IDLE;
        arr_addr  = req_addr;
        arr_wdata = req_wdata;
        if (acc_rd) begin
          addr_d = req_addr;
          if (RD_WAIT == 0) begin
            st_d           = MS_RD_RSP;
            rsp_valid_d    = 1'b1;
            rsp_from_arr_d = 1'b1;
          end else begin
            st_d  = MS_RD_WAIT;
            cnt_d = RD_LOAD;
          end
        end else if (acc_wr) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WR_WAIT == 0) begin
            arr_we    = 1'b1;
            wr_done_d = 1'b1;
          end else begin
            st_d  = WR_STATE;
            cnt_d = WR_LOAD;
          end
        end
      end
      MS_RD_WAIT: begin
        if (cnt_q == 4'd1) begin
          st_d           = MS_RD_RSP;
          rsp_valid_d    = 1'b1;
          rsp_from_arr_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MS_WR_WAIT, MS_DRAIN: begin
        if (cnt_q == 4'd1) begin
          arr_we    = 1'b1;
          wr_done_d = 1'b1;
          st_d      = MS_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
        // Only reachable while draining: ready is low in WR_WAIT.
        if (acc_rd) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wdata_q;
        end
      end
      default: st_d = MS_IDLE;
    endcase
    if (!clr) arr_we = 1'b0;
    req_ready_d = (st_d == MS_IDLE) || (st_d == MS_RD_RSP) || (st_d == MS_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      st_q           <= MS_IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rsp_valid_q    <= 1'b0;
      wr_done_q      <= 1'b0;
      proto_err_q    <= 1'b0;
      req_ready_q    <= 1'b0;
      rsp_from_arr_q <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      st_q           <= st_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      wr_done_q      <= wr_done_d;
      proto_err_q    <= proto_err_d;
      req_ready_q    <= req_ready_d;
      rsp_from_arr_q <= rsp_from_arr_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_from_arr_q ? arr_rdata : rsp_rdata_q;
  assign wr_done   = wr_done_q;
  assign proto_err = proto_err_q;

  mano_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (2**ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule
